// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side (start/a/b/cin)
// and completion side (busy/done/sum/cout), plus a read-only FSM state tap.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       state_dbg;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, state_dbg
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, state_dbg
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a registered carry,
// LSB first, with a start/busy/done handshake and registered outputs.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  // Handshake: start is honoured only on an edge where busy=0 (IDLE); a/b/cin
  // are sampled on that edge alone. done pulses for one cycle when sum/cout
  // update; start seen while busy=1 is dropped, not queued.

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_ps;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  always_comb begin
    w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    w_c    = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
    w_last = (r_cnt == CW'(WIDTH - 1));
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE:                w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_ps    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
      if (r_state == ST_IDLE && bus.start) begin
        r_a_sh  <= bus.a;
        r_b_sh  <= bus.b;
        r_carry <= bus.cin;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_ps    <= {w_s, r_ps[WIDTH-1:1]};
        r_carry <= w_c;
        r_cnt   <= r_cnt + 1'b1;
        // Only the final bit publishes; partial sums stay internal.
        if (w_last) begin
          r_sum  <= {w_s, r_ps[WIDTH-1:1]};
          r_cout <= w_c;
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.state_dbg = r_state;
endmodule
